rram_host_sequencer: RTL and testbench
======================================

Name: rram_host_sequencer

Overview:
- Host-side initiator for the RRAM controller's command interface.
- Accepts one operation request (write, read or forming) plus a target address.
- Drives the chip-enable / command-latch / address-latch sequence, two-phase opcode and address beats into the controller.
- Tracks the controller's ready/busy line through completion, then reports done or timeout error to the host logic.

Parameters:
- ADDR_BEATS, 2, number of 8-bit address beats per operation; address width is 8*ADDR_BEATS.
- GAP_CYCLES, 3, idle cycles between address_ready assertion and the second command, giving the controller time to reach its address-latched state.
- BUSY_TIMEOUT, 16, maximum cycles to wait for RB to fall after the second command.
- READY_TIMEOUT, 1024, maximum cycles to wait for RB to rise once busy.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  operation request; sampled only in IDLE.
- op  in  2  00 write, 01 read, 10 forming, 11 reserved.
- addr  in  8*ADDR_BEATS  target address; captured with req.
- busy  out  1  high from request accept until the done/err pulse, inclusive.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse (timeout or reserved op).
- CE  out  1  chip enable, active low.
- CLE  out  1  command latch enable.
- ALE  out  1  address latch enable.
- command  out  4  opcode bus.
- io_addr  out  8  address beat bus.
- command_ready  out  1  qualifies command for the controller.
- address_ready  out  1  all address beats delivered.
- RB  in  1  controller ready/busy; 1 = ready, 0 = busy.

Behaviour:
- Reset (async): state IDLE; CE=1; busy=0, done=0, err=0, CLE=0, ALE=0, command=0, io_addr=0, command_ready=0, address_ready=0; counters cleared.
- Reset mid-operation aborts immediately, with no done or err.
- Opcodes (package constants):
  - WRITE: CMD1 4'b0100, CMD2 4'b0010.
  - READ: CMD1 4'b0000, CMD2 4'b0011.
  - FORMING: CMD1 4'b0110, CMD2 4'b0111.
- IDLE, req=1 with op=11: next cycle err=1 for one cycle (busy=1 that cycle); no bus activity; back to IDLE.
- IDLE, req=1 with a valid op: capture op and addr; busy=1 next cycle; go to CMD1.
- CMD1 (1 cycle): CE=0, CLE=1, command=CMD1, command_ready=1.
- ADDR (ADDR_BEATS cycles): CE=0, ALE=1, io_addr = addr byte k, LSB byte first; CLE=0, command_ready=0.
- ADDR_RDY (1 cycle): ALE=0; address_ready goes 1 and stays 1 until the operation ends.
- GAP (GAP_CYCLES cycles): CE=0, no strobes. If GAP_CYCLES=0, skip this state.
- CMD2 (1 cycle): CLE=1, command=CMD2, command_ready=1.
- command holds its last driven value outside CMD states; it is qualified only by command_ready.
- WAIT_BUSY: wait for RB=0.
  - Seen within BUSY_TIMEOUT cycles: go to WAIT_READY.
  - Counter reaching BUSY_TIMEOUT: go to ERR.
- WAIT_READY: wait for RB=1.
  - Seen: go to DONE.
  - READY_TIMEOUT exceeded: go to ERR.
- DONE / ERR (1 cycle): done=1 or err=1; CE=1, address_ready=0; busy=1 this cycle, 0 next; back to IDLE.
- req is ignored while busy=1; there is no queuing.
- Latency, valid op with RB responding at once: req to done = 1 + 1 + ADDR_BEATS + 1 + GAP_CYCLES + 1 + 1 + 1 cycles (WAIT_BUSY and WAIT_READY each at least 1 cycle).
- Timeout counters saturate and are cleared on every state entry; width is clog2(max timeout)+1.
- RB is used directly; the controller is synchronous to clk.

Decomposition:
- Package rram_host_pkg holds:
  - op encodings;
  - the CMD1/CMD2 opcode constants above, shared with the control unit and its benches;
  - the state enum.
- One sub-module, rram_wait_timer: loadable down-counter with start, expire and clear, reused for the GAP, WAIT_BUSY and WAIT_READY states.

Test Plan:
- Write, addr=16'h3A5C, RB modelled to fall 2 cycles after CMD2 and rise 5 cycles later:
  - command sequence is 0100 then 0010;
  - io_addr beats are 5C then 3A;
  - address_ready stays high from ADDR_RDY to DONE;
  - a single done pulse; busy drops the next cycle.
- Read and forming ops: CMD1/CMD2 = 0000/0011 and 0110/0111 respectively; CE low for the whole sequence.
- RB never falls: err pulses exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry; no done; CE=1 after.
- op=11: err pulse 1 cycle after req; CE, CLE and ALE never toggle.
- rst_n asserted during ADDR: all outputs return to reset values asynchronously; a new write after reset completes normally.
- req held high across a whole operation: exactly one operation per IDLE visit; req while busy is ignored.

Source files
------------

// File: rtl/rram_host_pkg.sv
// Shared encodings for the RRAM host sequencer: op codes, controller opcodes
// for each operation's two command phases, and the sequencer state enum.
package rram_host_pkg;

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_READ    = 2'b01;
    localparam logic [1:0] OP_FORMING = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    localparam logic [3:0] WRITE_CMD1 = 4'b0100;
    localparam logic [3:0] WRITE_CMD2 = 4'b0010;
    localparam logic [3:0] READ_CMD1  = 4'b0000;
    localparam logic [3:0] READ_CMD2  = 4'b0011;
    localparam logic [3:0] FORM_CMD1  = 4'b0110;
    localparam logic [3:0] FORM_CMD2  = 4'b0111;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD1,
        ST_ADDR,
        ST_ADDR_RDY,
        ST_GAP,
        ST_CMD2,
        ST_WAIT_BUSY,
        ST_WAIT_READY,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic [3:0] cmd1_of(input logic [1:0] op_code);
        logic [3:0] cmd;
        case (op_code)
            OP_READ:    cmd = READ_CMD1;
            OP_FORMING: cmd = FORM_CMD1;
            default:    cmd = WRITE_CMD1;
        endcase
        return cmd;
    endfunction

    function automatic logic [3:0] cmd2_of(input logic [1:0] op_code);
        logic [3:0] cmd;
        case (op_code)
            OP_READ:    cmd = READ_CMD2;
            OP_FORMING: cmd = FORM_CMD2;
            default:    cmd = WRITE_CMD2;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/rram_wait_timer.sv
// Loadable saturating down-counter; expire marks the last cycle of a window
// of load_value cycles that begins the cycle after start.
module rram_wait_timer #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (start) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/rram_host_sequencer.sv
// Host-side initiator: issues CMD1, address beats and CMD2 to the RRAM
// controller, then follows RB to completion and reports done or err.
module rram_host_sequencer
    import rram_host_pkg::*;
#(
    parameter int ADDR_BEATS    = 2,
    parameter int GAP_CYCLES    = 3,
    parameter int BUSY_TIMEOUT  = 16,
    parameter int READY_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic [1:0]              op,
    input  logic [8*ADDR_BEATS-1:0] addr,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    CE,
    output logic                    CLE,
    output logic                    ALE,
    output logic [3:0]              command,
    output logic [7:0]              io_addr,
    output logic                    command_ready,
    output logic                    address_ready,
    input  logic                    RB,
    output logic [3:0]              dbg_state
);

    localparam int AW    = 8 * ADDR_BEATS;
    localparam int TMAX0 = (BUSY_TIMEOUT > READY_TIMEOUT) ? BUSY_TIMEOUT : READY_TIMEOUT;
    localparam int TMAX  = (GAP_CYCLES > TMAX0) ? GAP_CYCLES : TMAX0;
    localparam int TW    = $clog2(TMAX) + 1;
    localparam int BW    = (ADDR_BEATS > 1) ? $clog2(ADDR_BEATS) : 1;

    state_t          state, state_next;
    logic [1:0]      op_q;
    logic [AW-1:0]   addr_q;
    logic [BW-1:0]   beat_cnt;
    logic            timer_start, timer_clear, timer_expire;
    logic [TW-1:0]   timer_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_q     <= OP_WRITE;
            addr_q   <= '0;
            beat_cnt <= '0;
            command  <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && req) begin
                op_q   <= op;
                addr_q <= addr;
            end
            // Address shifts down one byte per beat so io_addr is always the low byte.
            if (state == ST_ADDR) begin
                beat_cnt <= beat_cnt + 1'b1;
                addr_q   <= addr_q >> 8;
            end else begin
                beat_cnt <= '0;
            end
            if (state == ST_IDLE && state_next == ST_CMD1) begin
                command <= cmd1_of(op);
            end else if (state != ST_CMD2 && state_next == ST_CMD2) begin
                command <= cmd2_of(op_q);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:       if (req) state_next = (op == OP_RSVD) ? ST_ERR : ST_CMD1;
            ST_CMD1:       state_next = ST_ADDR;
            ST_ADDR:       if (beat_cnt == BW'(ADDR_BEATS - 1)) state_next = ST_ADDR_RDY;
            ST_ADDR_RDY:   state_next = (GAP_CYCLES == 0) ? ST_CMD2 : ST_GAP;
            ST_GAP:        if (timer_expire) state_next = ST_CMD2;
            ST_CMD2:       state_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!RB) state_next = ST_WAIT_READY;
                else if (timer_expire) state_next = ST_ERR;
            end
            ST_WAIT_READY: begin
                if (RB) state_next = ST_DONE;
                else if (timer_expire) state_next = ST_ERR;
            end
            ST_DONE:       state_next = ST_IDLE;
            ST_ERR:        state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    // The timer is reloaded on entry to each timed state and cleared on return to idle.
    always_comb begin
        timer_start = 1'b0;
        timer_load  = '0;
        timer_clear = (state_next == ST_IDLE);
        if (state_next != state) begin
            case (state_next)
                ST_GAP: begin
                    timer_start = 1'b1;
                    timer_load  = TW'(GAP_CYCLES);
                end
                ST_WAIT_BUSY: begin
                    timer_start = 1'b1;
                    timer_load  = TW'(BUSY_TIMEOUT);
                end
                ST_WAIT_READY: begin
                    timer_start = 1'b1;
                    timer_load  = TW'(READY_TIMEOUT);
                end
                default: ;
            endcase
        end
    end

    rram_wait_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (timer_start),
        .clear      (timer_clear),
        .load_value (timer_load),
        .expire     (timer_expire)
    );

    always_comb begin
        busy          = (state != ST_IDLE);
        done          = (state == ST_DONE);
        err           = (state == ST_ERR);
        CE            = 1'b1;
        CLE           = 1'b0;
        ALE           = 1'b0;
        command_ready = 1'b0;
        address_ready = 1'b0;
        io_addr       = 8'h00;
        case (state)
            ST_CMD1, ST_CMD2: begin
                CE            = 1'b0;
                CLE           = 1'b1;
                command_ready = 1'b1;
                address_ready = (state == ST_CMD2);
            end
            ST_ADDR: begin
                CE      = 1'b0;
                ALE     = 1'b1;
                io_addr = addr_q[7:0];
            end
            ST_ADDR_RDY, ST_GAP, ST_WAIT_BUSY, ST_WAIT_READY: begin
                CE            = 1'b0;
                address_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_rram_host_sequencer.sv
// Self-checking bench for rram_host_sequencer: directed and random operations
// scored against cycle-level expectations derived from the operation rules.
module tb_rram_host_sequencer;

    localparam int ADDR_BEATS    = 2;
    localparam int GAP_CYCLES    = 3;
    localparam int BUSY_TIMEOUT  = 16;
    localparam int READY_TIMEOUT = 1024;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [1:0]  op;
    logic [15:0] addr;
    logic        busy, done, err, CE, CLE, ALE;
    logic [3:0]  command;
    logic [7:0]  io_addr;
    logic        command_ready, address_ready;
    logic        RB;
    logic [3:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    logic [3:0] cmd1_tbl [4] = '{4'b0100, 4'b0000, 4'b0110, 4'b0000};
    logic [3:0] cmd2_tbl [4] = '{4'b0010, 4'b0011, 4'b0111, 4'b0000};

    rram_host_sequencer #(
        .ADDR_BEATS    (ADDR_BEATS),
        .GAP_CYCLES    (GAP_CYCLES),
        .BUSY_TIMEOUT  (BUSY_TIMEOUT),
        .READY_TIMEOUT (READY_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .op            (op),
        .addr          (addr),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .CE            (CE),
        .CLE           (CLE),
        .ALE           (ALE),
        .command       (command),
        .io_addr       (io_addr),
        .command_ready (command_ready),
        .address_ready (address_ready),
        .RB            (RB),
        .dbg_state     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reset values of {CE,busy,done,err,CLE,ALE,command,io_addr,command_ready,address_ready}.
    function automatic logic [19:0] out_vec();
        return {CE, busy, done, err, CLE, ALE, command, io_addr, command_ready, address_ready};
    endfunction

    // One operation, called at a negedge. RB falls `fall` cycles after the CMD2
    // cycle and rises `rise` cycles later; fall < 0 means RB never falls.
    task automatic run_op(input string name, input logic [1:0] op_i, input logic [15:0] a,
                          input int fall, input int rise, input bit hold);
        int c2, exp_end, exp_ce, exp_ar, exp_strobe_cle, exp_strobe_ale;
        int n_ce, n_ar, n_busy, n_done, n_err, done_at, err_at, n_cle, n_ale;
        bit is_err;
        logic ce_end, ar_end;
        logic [3:0] exp_cmd[$];
        logic [7:0] exp_beat[$];
        logic [3:0] got_cmd[$];
        logic [7:0] got_beat[$];
        c2 = 3 + ADDR_BEATS + GAP_CYCLES;
        n_ce = 0; n_ar = 0; n_busy = 0; n_done = 0; n_err = 0;
        done_at = -1; err_at = -1; n_cle = 0; n_ale = 0;
        ce_end = 1'bx; ar_end = 1'bx;
        if (op_i == 2'b11) begin
            exp_end = 1; is_err = 1'b1; exp_ce = 0; exp_ar = 0;
            exp_strobe_cle = 0; exp_strobe_ale = 0;
        end else begin
            exp_cmd.push_back(cmd1_tbl[op_i]);
            exp_cmd.push_back(cmd2_tbl[op_i]);
            for (int k = 0; k < ADDR_BEATS; k++) exp_beat.push_back(a[8*k +: 8]);
            if (fall < 0) begin
                exp_end = c2 + 1 + BUSY_TIMEOUT;
                is_err  = 1'b1;
            end else begin
                exp_end = c2 + fall + rise + 1;
                is_err  = 1'b0;
            end
            exp_ce = exp_end - 1;
            exp_ar = exp_end - (2 + ADDR_BEATS);
            exp_strobe_cle = 2;
            exp_strobe_ale = ADDR_BEATS;
        end

        RB = 1'b1; req = 1'b1; op = op_i; addr = a;
        for (int cyc = 1; cyc <= exp_end + 2; cyc++) begin
            @(negedge clk);
            if (!hold) req = 1'b0;
            if (cyc <= exp_end + 1) begin
                if (command_ready) got_cmd.push_back(command);
                if (ALE) got_beat.push_back(io_addr);
                if (!CE) n_ce++;
                if (address_ready) n_ar++;
                if (busy) n_busy++;
                if (CLE) n_cle++;
                if (ALE) n_ale++;
                if (done) begin n_done++; done_at = cyc; end
                if (err) begin n_err++; err_at = cyc; end
                if (cyc == exp_end) begin ce_end = CE; ar_end = address_ready; end
            end else begin
                check({name, "_busy_after"}, 32'(busy), 32'(hold));
            end
            if (fall >= 0 && cyc == c2 + fall) RB = 1'b0;
            if (fall >= 0 && cyc == c2 + fall + rise) RB = 1'b1;
        end

        check({name, "_cmd_count"}, got_cmd.size(), exp_cmd.size());
        for (int i = 0; i < exp_cmd.size(); i++)
            check({name, "_cmd"}, (i < got_cmd.size()) ? 32'(got_cmd[i]) : 32'hDEAD, 32'(exp_cmd[i]));
        check({name, "_beat_count"}, got_beat.size(), exp_beat.size());
        for (int i = 0; i < exp_beat.size(); i++)
            check({name, "_beat"}, (i < got_beat.size()) ? 32'(got_beat[i]) : 32'hDEAD, 32'(exp_beat[i]));
        check({name, "_ce_low_cycles"}, n_ce, exp_ce);
        check({name, "_ce_at_end"}, 32'(ce_end), 32'd1);
        check({name, "_addr_ready_cycles"}, n_ar, exp_ar);
        check({name, "_addr_ready_at_end"}, 32'(ar_end), 32'd0);
        check({name, "_busy_cycles"}, n_busy, exp_end);
        check({name, "_done_count"}, n_done, is_err ? 0 : 1);
        check({name, "_err_count"}, n_err, is_err ? 1 : 0);
        check({name, "_pulse_cycle"}, is_err ? err_at : done_at, exp_end);
        check({name, "_cle_cycles"}, n_cle, exp_strobe_cle);
        check({name, "_ale_cycles"}, n_ale, exp_strobe_ale);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [15:0] r_addr;
        rst_n = 1'b0; req = 1'b0; op = 2'b00; addr = 16'h0000; RB = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(out_vec()), 32'h80000);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'(out_vec()), 32'h80000);

        run_op("write_3a5c", 2'b00, 16'h3A5C, 2, 5, 1'b0);
        run_op("read_min_latency", 2'b01, 16'hC3E1, 1, 1, 1'b0);
        run_op("forming", 2'b10, 16'h0F70, 4, 3, 1'b0);
        run_op("busy_timeout", 2'b00, 16'h5AA5, -1, 0, 1'b0);
        run_op("reserved_op", 2'b11, 16'hFFFF, -1, 0, 1'b0);

        // Abort during the address phase.
        req = 1'b1; op = 2'b00; addr = 16'h1234;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("addr_phase_reached", {31'd0, ALE}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", 32'(out_vec()), 32'h80000);
        @(negedge clk);
        check("held_reset_outputs", 32'(out_vec()), 32'h80000);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("write_after_reset", 2'b00, 16'hBEEF, 3, 2, 1'b0);

        run_op("req_held", 2'b01, 16'h7E81, 1, 2, 1'b1);
        req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_addr = 16'($urandom);
            run_op("random", r_op, r_addr, int'($urandom_range(1, 10)), int'($urandom_range(1, 8)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
